// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall controller: drives PC, IF/ID and ID/EX enables and the ID/EX WB-control field.
// Optional statistics counters are enabled with PIPE_HAZARD_STATS_EN.
module pipe_hazard_ctrl #(
    parameter int REG_AW    = 5,
    parameter int LOAD_LAT  = 1,
    parameter int FLUSH_CYC = 1,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_memread,
    input  logic [1:0]        id_wb_ctrl,
    input  logic              branch_taken,
    input  logic              mem_busy,
    output logic              pc_en,
    output logic              ifid_en,
    output logic              ifid_flush,
    output logic              idex_en,
    output logic [1:0]        wb_ctrl_out,
    output logic [1:0]        state_out
`ifdef PIPE_HAZARD_STATS_EN
    ,
    output logic [CNT_W-1:0]  stall_count,
    output logic [CNT_W-1:0]  flush_count
`endif
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2,
        FLUSH    = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        OC_NORMAL,
        OC_FREEZE,
        OC_BUB_LU,
        OC_BUB_BR
    } oclass_e;

    localparam logic [3:0] LU_INIT = 4'(LOAD_LAT - 1);
    localparam logic [3:0] BR_INIT = 4'(FLUSH_CYC - 1);

    state_e     state_q, state_d;
    state_e     ret_q, ret_d;
    logic [3:0] cnt_q, cnt_d;
    oclass_e    oc;
    logic       haz;

    assign haz = ex_memread && (ex_rd != '0) && ((ex_rd == id_rs1) || (ex_rd == id_rs2));

    always_ff @(posedge clk) begin
        state_q <= state_d;
        ret_q   <= ret_d;
        cnt_q   <= cnt_d;
    end

    always_comb begin
        state_d = state_q;
        ret_d   = ret_q;
        cnt_d   = cnt_q;
        oc      = OC_FREEZE;
        case (state_q)
            RUN: begin
                if (mem_busy) begin
                    state_d = MEM_WAIT;
                    ret_d   = RUN;
                end else if (branch_taken) begin
                    oc = OC_BUB_BR;
                    if (FLUSH_CYC > 1) begin
                        state_d = FLUSH;
                        cnt_d   = BR_INIT;
                    end
                end else if (haz) begin
                    oc = OC_BUB_LU;
                    if (LOAD_LAT > 1) begin
                        state_d = LU_STALL;
                        cnt_d   = LU_INIT;
                    end
                end else begin
                    oc = OC_NORMAL;
                end
            end
            LU_STALL, FLUSH: begin
                // Counter holds across a memory stall and resumes on return.
                if (mem_busy) begin
                    state_d = MEM_WAIT;
                    ret_d   = state_q;
                end else begin
                    oc    = (state_q == LU_STALL) ? OC_BUB_LU : OC_BUB_BR;
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q <= 4'd1) state_d = RUN;
                end
            end
            default: begin
                // The release cycle is still a freeze so the memory result can land.
                if (!mem_busy) state_d = ret_q;
            end
        endcase
        if (reset) begin
            state_d = RUN;
            ret_d   = RUN;
            cnt_d   = 4'd0;
        end
    end

    always_comb begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        ifid_flush  = 1'b0;
        idex_en     = 1'b0;
        wb_ctrl_out = 2'b00;
        state_out   = reset ? RUN : state_q;
        if (!reset) begin
            case (oc)
                OC_NORMAL: begin
                    pc_en       = 1'b1;
                    ifid_en     = 1'b1;
                    idex_en     = 1'b1;
                    wb_ctrl_out = id_wb_ctrl;
                end
                OC_BUB_LU: idex_en = 1'b1;
                OC_BUB_BR: begin
                    pc_en      = 1'b1;
                    ifid_en    = 1'b1;
                    ifid_flush = 1'b1;
                    idex_en    = 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef PIPE_HAZARD_STATS_EN
    logic [CNT_W-1:0] stall_count_q, stall_count_d;
    logic [CNT_W-1:0] flush_count_q, flush_count_d;

    always_comb begin
        stall_count_d = stall_count_q;
        flush_count_d = flush_count_q;
        if (reset) begin
            stall_count_d = '0;
            flush_count_d = '0;
        end else begin
            if ((oc == OC_FREEZE || oc == OC_BUB_LU) && stall_count_q != '1)
                stall_count_d = stall_count_q + 1'b1;
            if (oc == OC_BUB_BR && flush_count_q != '1)
                flush_count_d = flush_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        stall_count_q <= stall_count_d;
        flush_count_q <= flush_count_d;
    end

    assign stall_count = stall_count_q;
    assign flush_count = flush_count_q;
`endif

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Hazard/stall controller in the pipelined datapath.
- Sits upstream of the ID/EX and IF/ID pipeline registers. Drives their enables, and supplies the 2-bit WB control field (RegWrite, MemToReg) loaded into the ID/EX WB-control register.
- Inserts bubbles on load-use hazards, flushes on taken branches, and freezes the pipe while memory is busy.

Parameters:
- REG_AW, 5, register-address width.
- LOAD_LAT, 1, bubble cycles inserted per load-use hazard (1..15).
- FLUSH_CYC, 1, bubble cycles inserted per taken branch (1..15).
- CNT_W, 16, width of statistics counters (optional feature only).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- id_rs1  in  REG_AW  ID-stage source register 1.
- id_rs2  in  REG_AW  ID-stage source register 2.
- ex_rd  in  REG_AW  EX-stage destination register.
- ex_memread  in  1  EX-stage instruction is a load.
- id_wb_ctrl  in  2  WB control decoded in ID.
- branch_taken  in  1  branch resolved taken in EX.
- mem_busy  in  1  data memory not ready; whole pipe must hold.
- pc_en  out  1  PC register enable.
- ifid_en  out  1  IF/ID register enable.
- ifid_flush  out  1  IF/ID register loads NOP.
- idex_en  out  1  ID/EX register enable (including WB-control field).
- wb_ctrl_out  out  2  WB control to ID/EX; 2'b00 means bubble.
- state_out  out  2  current FSM state (debug).

Behaviour:
- State encoding: RUN=0, LU_STALL=1, MEM_WAIT=2, FLUSH=3.
- One 4-bit down-counter, cnt.
- Outputs are combinational from state and current inputs.
- State and cnt update on the rising edge of clk.
- Hazard condition: `haz = ex_memread && ex_rd != 0 && (ex_rd == id_rs1 || ex_rd == id_rs2)`.
- Reset (synchronous, highest priority): state=RUN, cnt=0.
- While reset is asserted, outputs are: pc_en=0, ifid_en=0, idex_en=0, ifid_flush=0, wb_ctrl_out=00, state_out=0.
- Output classes:
  - Normal: pc_en=1, ifid_en=1, idex_en=1, ifid_flush=0, wb_ctrl_out=id_wb_ctrl.
  - Freeze: all enables 0, ifid_flush=0, wb_ctrl_out=00.
  - Bubble-LU: pc_en=0, ifid_en=0, idex_en=1, ifid_flush=0, wb_ctrl_out=00.
  - Bubble-BR: pc_en=1, ifid_en=1, ifid_flush=1, idex_en=1, wb_ctrl_out=00.
- RUN, priority mem_busy > branch_taken > haz > none:
  - mem_busy: Freeze; next=MEM_WAIT; cnt held.
  - branch_taken: Bubble-BR; if FLUSH_CYC>1, next=FLUSH with cnt=FLUSH_CYC-1; otherwise stay in RUN.
  - haz: Bubble-LU; if LOAD_LAT>1, next=LU_STALL with cnt=LOAD_LAT-1; otherwise stay in RUN.
  - none: Normal.
- LU_STALL:
  - mem_busy: Freeze; next=MEM_WAIT; cnt held.
  - Otherwise: Bubble-LU; cnt decrements; when cnt reaches 1, next=RUN.
  - branch_taken is ignored (EX holds a bubble).
- FLUSH:
  - mem_busy: Freeze; next=MEM_WAIT; cnt held.
  - Otherwise: Bubble-BR; cnt decrements; when cnt reaches 1, next=RUN.
- MEM_WAIT:
  - Freeze while mem_busy=1.
  - The cycle mem_busy=0 is a Freeze cycle.
  - Return state is recorded on entry to MEM_WAIT (2-bit ret register):
    - Entered from LU_STALL or FLUSH: return to that state, with cnt resumed.
    - Entered from RUN: return to RUN, and the RUN decision is re-evaluated the following cycle.
- Invariant: ifid_flush=1 only when ifid_en=1.
- Invariant: pc_en=0 implies ifid_en=0.
- A reset asserted mid-stall abandons the stall: next state RUN, cnt=0, ret=RUN.

Optional Feature:
- Macro: PIPE_HAZARD_STATS_EN.
- When defined, adds output ports stall_count[CNT_W] and flush_count[CNT_W]. Both are saturating counters, zeroed by reset.
  - stall_count increments on each Bubble-LU or Freeze cycle.
  - flush_count increments on each Bubble-BR cycle.
  - Both counters hold at all-ones.
- When not defined, neither port nor counter exists; behaviour is otherwise identical.

Test Plan:
- Reset: reset=1 for 2 cycles with any inputs -> all enables 0, wb_ctrl_out=00, state_out=0. Release with no hazard, id_wb_ctrl=2'b10 -> Normal, wb_ctrl_out=10.
- Load-use, LOAD_LAT=1: ex_memread=1, ex_rd=5, id_rs2=5 -> one cycle pc_en=0, ifid_en=0, idex_en=1, wb_ctrl_out=00. Drop ex_memread next cycle -> Normal.
- Load to r0: ex_rd=0, id_rs1=0, ex_memread=1 -> no stall, Normal.
- Branch, FLUSH_CYC=2: branch_taken pulse 1 cycle -> 2 consecutive cycles with ifid_flush=1, wb_ctrl_out=00, then Normal. state_out sequence 0,3,0.
- Memory stall during load-use, LOAD_LAT=3: hazard, then mem_busy=1 for 4 cycles at the second bubble -> 4 Freeze cycles, then 1 Freeze on release, then the remaining bubble cycle, then RUN. Total LU bubbles = 3.
- Priority: mem_busy, branch_taken and haz all 1 in RUN -> Freeze, state_out=2. With PIPE_HAZARD_STATS_EN defined, stall_count increments by 1 per Freeze cycle and saturates at 16'hFFFF.
